// File: rtl/mult_seq_param.sv
// rtl/mult_seq_param.sv - sequential shift-add multiplier, unsigned or two's-complement
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operands a, b, signed_mode are presented
//   in_ready    block accepts operands this cycle (IDLE only, 0 while in reset)
//   a, b        multiplicand / multiplier, WIDTH bits
//   signed_mode 1 = two's-complement operands, 0 = unsigned
//   out_valid   product is valid (DONE only)
//   out_ready   consumer takes the product
//   product     2*WIDTH-bit result, held until the next DONE entry
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   a_sh;      // extended a, pre-shifted to the current bit weight
  logic [WIDTH-1:0] b_sh;     // captured b, current bit always in b_sh[0]
  logic            sm_q;
  logic [CW-1:0]   cnt;
  logic            rdy_q;
  logic            accept;
  logic            last_bit;
  logic [PW-1:0]   acc_sum;

  // rdy_q is only ever 1 in IDLE, so it alone qualifies acceptance.
  assign accept    = rdy_q & in_valid;
  assign last_bit  = (cnt == LAST);
  assign in_ready  = rdy_q;
  assign out_valid = (state == DONE);

  // The MSB of a two's-complement multiplier carries negative weight.
  always_comb begin
    acc_sum = acc;
    if (b_sh[0]) begin
      if (last_bit && sm_q) acc_sum = acc - a_sh;
      else                  acc_sum = acc + a_sh;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // in_ready is registered so it stays low during reset and rises only
  // after the first clock edge with rst_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sm_q    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh <= {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
            b_sh <= b;
            sm_q <= signed_mode;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          acc  <= acc_sum;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          if (last_bit) product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// tb/tb_mult_seq_param.sv - directed and random checks for mult_seq_param
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv8 = 0, ir8, sm8 = 0, ov8, or8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;

  logic        iv16 = 0, ir16, sm16 = 0, ov16, or16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  mult_seq_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input bit s);
    longint lx, ly;
    lx = s ? {{48{x[15]}}, x} : {48'd0, x};
    ly = s ? {{48{y[15]}}, y} : {48'd0, y};
    return 32'(lx * ly);
  endfunction

  // Issue one WIDTH=8 operation from a negedge; returns the product and the
  // number of edges from acceptance until out_valid was seen.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                     output logic [15:0] p, output int lat);
    int n;
    n = 0;
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    chk("op8_in_ready", {31'd0, ir8}, 32'd1);
    a8 = ta; b8 = tb; sm8 = tsm; iv8 = 1; or8 = 0;
    @(negedge clk);
    iv8 = 0;
    lat = 0;
    while (!ov8 && lat < 100) begin @(negedge clk); lat++; end
    p = p8;
    or8 = 1;
    @(negedge clk);
    or8 = 0;
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tsm,
                      output logic [31:0] p, output int lat);
    int n;
    n = 0;
    while (!ir16 && n < 50) begin @(negedge clk); n++; end
    a16 = ta; b16 = tb; sm16 = tsm; iv16 = 1; or16 = 0;
    @(negedge clk);
    iv16 = 0;
    lat = 0;
    while (!ov16 && lat < 100) begin @(negedge clk); lat++; end
    p = p16;
    or16 = 1;
    @(negedge clk);
    or16 = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          tbl[12];
    logic [15:0]   p;
    logic [31:0]   q;
    logic [15:0]   hold_p;
    int            lat;
    int            n;

    tbl[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[4]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
    tbl[5]  = '{8'h00, 8'hAB, 1'b1, 16'h0000};
    tbl[6]  = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    tbl[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[8]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    tbl[9]  = '{8'h01, 8'h80, 1'b1, 16'hFF80};
    tbl[10] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    tbl[11] = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};

    // reset state, before any clock edge
    #2;
    chk("rst_in_ready", {31'd0, ir8}, 32'd0);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_product", {16'd0, p8}, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("rst_hold_in_ready", {31'd0, ir8}, 32'd0);
    rst_n = 1;
    chk("rst_release_no_ready", {31'd0, ir8}, 32'd0);
    @(negedge clk);
    chk("idle_in_ready", {31'd0, ir8}, 32'd1);

    // out_ready in IDLE is ignored
    or8 = 1;
    @(negedge clk);
    chk("idle_out_ready_ignored", {31'd0, ov8}, 32'd0);
    or8 = 0;

    foreach (tbl[i]) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].sm, p, lat);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_product", i), {16'd0, p}, {16'd0, tbl[i].exp});
    end

    // DONE held with out_ready=0 while inputs toggle; out_ready=1 in CALC ignored
    a8 = 8'h0D; b8 = 8'h0B; sm8 = 0; iv8 = 1;
    @(negedge clk);
    iv8 = 0; or8 = 1;
    @(negedge clk);
    chk("calc_out_ready_ignored", {31'd0, ov8}, 32'd0);
    or8 = 0;
    n = 0;
    while (!ov8 && n < 20) begin @(negedge clk); n++; end
    chk("hold_reach_done", {31'd0, ov8}, 32'd1);
    hold_p = p8;
    chk("hold_product_first", {16'd0, hold_p}, 32'h0000_008F);
    for (int k = 0; k < 5; k++) begin
      a8 = ~a8; b8 = b8 + 8'h11; iv8 = ~iv8; sm8 = ~sm8;
      @(negedge clk);
      chk("hold_out_valid", {31'd0, ov8}, 32'd1);
      chk("hold_product", {16'd0, p8}, {16'd0, hold_p});
      chk("hold_in_ready", {31'd0, ir8}, 32'd0);
    end
    iv8 = 0; or8 = 1;
    @(negedge clk);
    or8 = 0;
    chk("hold_release_out_valid", {31'd0, ov8}, 32'd0);
    chk("hold_release_in_ready", {31'd0, ir8}, 32'd1);
    chk("product_kept_after_done", {16'd0, p8}, {16'd0, hold_p});

    // reset at CALC bit 3 aborts, then a fresh operation works
    a8 = 8'hFF; b8 = 8'hFF; sm8 = 0; iv8 = 1;
    @(negedge clk);
    iv8 = 0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_out_valid", {31'd0, ov8}, 32'd0);
    chk("abort_product", {16'd0, p8}, 32'd0);
    chk("abort_in_ready", {31'd0, ir8}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("abort_idle_after_release", {31'd0, ir8}, 32'd1);
    chk("abort_no_stale_valid", {31'd0, ov8}, 32'd0);
    op8(8'd3, 8'd5, 1'b0, p, lat);
    chk("abort_next_latency", lat, 8);
    chk("abort_next_product", {16'd0, p}, 32'd15);

    // back-to-back streaming, out_ready and in_valid held high
    begin
      logic [15:0] exp_q[$];
      int          last_acc;
      int          accepts;
      int          results;
      logic [7:0]  na, nb;
      last_acc = -1; accepts = 0; results = 0;
      or8 = 1;
      for (int cyc = 0; cyc < 80; cyc++) begin
        if (ov8) begin
          if (exp_q.size() > 0) chk("stream_product", {16'd0, p8}, {16'd0, exp_q.pop_front()});
          else chk("stream_extra_result", 32'd1, 32'd0);
          results++;
        end
        if (ir8 && accepts < 5) begin
          if (last_acc >= 0) chk("stream_interval", cyc - last_acc, 10);
          last_acc = cyc;
          na = 8'(accepts * 37 + 5);
          nb = 8'(accepts * 53 + 9);
          a8 = na; b8 = nb; sm8 = 0; iv8 = 1;
          exp_q.push_back(16'(na) * 16'(nb));
          accepts++;
        end else if (accepts >= 5) begin
          iv8 = 0;
        end
        @(negedge clk);
      end
      or8 = 0; iv8 = 0;
      chk("stream_accept_count", accepts, 5);
      chk("stream_result_count", results, 5);
    end

    // WIDTH=16 random in both modes, with forced zero operands
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(1, 0));
      if (i % 50 == 7)  ra = 16'h0000;
      if (i % 50 == 23) rb = 16'h0000;
      if (i == 1) begin ra = 16'h8000; rb = 16'h8000; rs = 1; end
      if (i == 2) begin ra = 16'hFFFF; rb = 16'hFFFF; rs = 0; end
      op16(ra, rb, rs, q, lat);
      if (i < 3) chk("w16_latency", lat, 16);
      chk($sformatf("w16_%0d_%h_%h_%0d", i, ra, rb, rs), q, ref16(ra, rb, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
